// File: rtl/accel_mem_arbiter_if.sv
// Bus, core and bank-side signal bundle for the interleaved memory arbiter.
// slave = arbiter view, master = requesters plus RAM banks.
interface accel_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BANKS  = 2
);
    localparam int BSEL = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0;
    localparam int BAW  = ADDR_WIDTH - BSEL;
    localparam int BEW  = DATA_WIDTH / 8;

    logic                            mem_req;
    logic [ADDR_WIDTH-1:0]           mem_addr;
    logic                            mem_we;
    logic [BEW-1:0]                  mem_be;
    logic [DATA_WIDTH-1:0]           mem_wdata;
    logic                            mem_gnt;
    logic                            mem_rvalid;
    logic [DATA_WIDTH-1:0]           mem_rdata;

    logic                            core_req;
    logic [ADDR_WIDTH-1:0]           core_addr;
    logic                            core_we;
    logic [BEW-1:0]                  core_be;
    logic [DATA_WIDTH-1:0]           core_wdata;
    logic                            core_gnt;
    logic                            core_rvalid;
    logic [DATA_WIDTH-1:0]           core_rdata;

    logic [NUM_BANKS-1:0]            bank_en;
    logic [NUM_BANKS-1:0]            bank_we;
    logic [NUM_BANKS*BAW-1:0]        bank_addr;
    logic [NUM_BANKS*BEW-1:0]        bank_be;
    logic [NUM_BANKS*DATA_WIDTH-1:0] bank_wdata;
    logic [NUM_BANKS*DATA_WIDTH-1:0] bank_rdata;

    modport slave (
        input  mem_req, mem_addr, mem_we, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  core_req, core_addr, core_we, core_be, core_wdata,
        output core_gnt, core_rvalid, core_rdata,
        output bank_en, bank_we, bank_addr, bank_be, bank_wdata,
        input  bank_rdata
    );

    modport master (
        output mem_req, mem_addr, mem_we, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output core_req, core_addr, core_we, core_be, core_wdata,
        input  core_gnt, core_rvalid, core_rdata,
        input  bank_en, bank_we, bank_addr, bank_be, bank_wdata,
        output bank_rdata
    );
endinterface

// File: rtl/accel_mem_arbiter.sv
// Word-interleaved N-bank arbiter for bus and accelerator core, plus run-control FSM and sticky errors.
// Latency: grant is combinational, read data 1 cycle after grant; backpressure: same-bank conflict in RUN stalls the bus up to STALL_MAX cycles.
module accel_mem_arbiter #(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_BANKS      = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int STALL_MAX      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       done,
    output logic       busy,
    output logic [1:0] accel_state,
    output logic [1:0] accel_error,
    output logic       core_start,
    output logic       core_abort,
    input  logic       core_done,
    accel_mem_arbiter_if.slave mif
);
    localparam int BSEL   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0;
    localparam int IW     = (BSEL > 0) ? BSEL : 1;
    localparam int BAW    = ADDR_WIDTH - BSEL;
    localparam int BEW    = DATA_WIDTH / 8;
    localparam int WDW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int WD_LIM = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam int SCW    = (STALL_MAX > 0) ? $clog2(STALL_MAX + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DONE  = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    function automatic logic [IW-1:0] bank_of(input logic [ADDR_WIDTH-1:0] a);
        return IW'(a & ADDR_WIDTH'(NUM_BANKS - 1));
    endfunction

    function automatic logic [BAW-1:0] baddr_of(input logic [ADDR_WIDTH-1:0] a);
        return BAW'(a >> BSEL);
    endfunction

    state_t          state_q, state_d;
    logic            start_q;
    logic [WDW-1:0]  wd_q, wd_d;
    logic [1:0]      err_q, err_d;
    logic            core_start_q, core_start_d;
    logic            core_abort_q, core_abort_d;
    logic [SCW-1:0]  stall_q, stall_d;

    logic            mem_rvld_q, core_rvld_q;
    logic [IW-1:0]   mem_rbank_q, core_rbank_q;
    logic [DATA_WIDTH-1:0] mem_rhold_q, core_rhold_q;
    logic [DATA_WIDTH-1:0] mem_rd_c, core_rd_c;

    logic            run;
    logic [IW-1:0]   mem_bank, core_bank;
    logic            mem_gnt_c, core_gnt_c;

    logic [NUM_BANKS-1:0]            bank_en_c, bank_we_c;
    logic [NUM_BANKS*BAW-1:0]        bank_addr_c;
    logic [NUM_BANKS*BEW-1:0]        bank_be_c;
    logic [NUM_BANKS*DATA_WIDTH-1:0] bank_wdata_c;

    assign run       = (state_q == S_RUN);
    assign mem_bank  = bank_of(mif.mem_addr);
    assign core_bank = bank_of(mif.core_addr);

    // Run-control FSM: next state, watchdog, sticky errors, one-cycle pulses
    always_comb begin
        state_d      = state_q;
        wd_d         = wd_q;
        err_d        = err_q;
        core_start_d = 1'b0;
        core_abort_d = 1'b0;
        if (mif.core_req && !run) begin
            err_d[1] = 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (start && !start_q) begin
                    state_d      = S_RUN;
                    core_start_d = 1'b1;
                    wd_d         = '0;
                    err_d        = '0;
                end
            end
            S_RUN: begin
                if (TIMEOUT_CYCLES != 0) begin
                    wd_d = wd_q + 1'b1;
                end
                if (core_done) begin
                    state_d = S_DONE;
                end else if ((TIMEOUT_CYCLES != 0) && (wd_q == WDW'(WD_LIM))) begin
                    state_d  = S_ERROR;
                    err_d[0] = 1'b1;
                end else if (!start) begin
                    state_d      = S_IDLE;
                    core_abort_d = 1'b1;
                end
            end
            default: begin
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // Grant logic; a saturated stall counter flips a same-bank conflict in the bus's favour
    always_comb begin
        mem_gnt_c  = mif.mem_req;
        core_gnt_c = 1'b0;
        if (run) begin
            core_gnt_c = mif.core_req;
            if (mif.mem_req && mif.core_req && (mem_bank == core_bank)) begin
                if (stall_q == SCW'(STALL_MAX)) begin
                    core_gnt_c = 1'b0;
                end else begin
                    mem_gnt_c = 1'b0;
                end
            end
        end
        if (mif.mem_req && !mem_gnt_c) begin
            stall_d = stall_q + 1'b1;
        end else begin
            stall_d = '0;
        end
    end

    always_comb begin
        bank_en_c    = '0;
        bank_we_c    = '0;
        bank_addr_c  = '0;
        bank_be_c    = '0;
        bank_wdata_c = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (mem_gnt_c && (mem_bank == IW'(b))) begin
                bank_en_c[b]                            = 1'b1;
                bank_we_c[b]                            = mif.mem_we;
                bank_addr_c[b*BAW +: BAW]               = baddr_of(mif.mem_addr);
                bank_be_c[b*BEW +: BEW]                 = mif.mem_be;
                bank_wdata_c[b*DATA_WIDTH +: DATA_WIDTH] = mif.mem_wdata;
            end else if (core_gnt_c && (core_bank == IW'(b))) begin
                bank_en_c[b]                            = 1'b1;
                bank_we_c[b]                            = mif.core_we;
                bank_addr_c[b*BAW +: BAW]               = baddr_of(mif.core_addr);
                bank_be_c[b*BEW +: BEW]                 = mif.core_be;
                bank_wdata_c[b*DATA_WIDTH +: DATA_WIDTH] = mif.core_wdata;
            end
        end
    end

    // Read return: live bank data while valid, otherwise the last delivered word
    always_comb begin
        mem_rd_c  = mem_rhold_q;
        core_rd_c = core_rhold_q;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (mem_rvld_q && (mem_rbank_q == IW'(b))) begin
                mem_rd_c = mif.bank_rdata[b*DATA_WIDTH +: DATA_WIDTH];
            end
            if (core_rvld_q && (core_rbank_q == IW'(b))) begin
                core_rd_c = mif.bank_rdata[b*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            start_q      <= 1'b0;
            wd_q         <= '0;
            err_q        <= '0;
            core_start_q <= 1'b0;
            core_abort_q <= 1'b0;
            stall_q      <= '0;
            mem_rvld_q   <= 1'b0;
            core_rvld_q  <= 1'b0;
            mem_rbank_q  <= '0;
            core_rbank_q <= '0;
            mem_rhold_q  <= '0;
            core_rhold_q <= '0;
        end else begin
            state_q      <= state_d;
            start_q      <= start;
            wd_q         <= wd_d;
            err_q        <= err_d;
            core_start_q <= core_start_d;
            core_abort_q <= core_abort_d;
            stall_q      <= stall_d;
            mem_rvld_q   <= mem_gnt_c && !mif.mem_we;
            core_rvld_q  <= core_gnt_c && !mif.core_we;
            if (mem_gnt_c) begin
                mem_rbank_q <= mem_bank;
            end
            if (core_gnt_c) begin
                core_rbank_q <= core_bank;
            end
            mem_rhold_q  <= mem_rd_c;
            core_rhold_q <= core_rd_c;
        end
    end

    assign done        = (state_q == S_DONE) || (state_q == S_ERROR);
    assign busy        = run;
    assign accel_state = state_q;
    assign accel_error = err_q;
    assign core_start  = core_start_q;
    assign core_abort  = core_abort_q;

    assign mif.mem_gnt     = mem_gnt_c;
    assign mif.core_gnt    = core_gnt_c;
    assign mif.mem_rvalid  = mem_rvld_q;
    assign mif.core_rvalid = core_rvld_q;
    assign mif.mem_rdata   = mem_rd_c;
    assign mif.core_rdata  = core_rd_c;
    assign mif.bank_en     = bank_en_c;
    assign mif.bank_we     = bank_we_c;
    assign mif.bank_addr   = bank_addr_c;
    assign mif.bank_be     = bank_be_c;
    assign mif.bank_wdata  = bank_wdata_c;
endmodule

// File: tb/tb_accel_mem_arbiter.sv
// Directed bench for accel_mem_arbiter with 4 banks, 16-cycle watchdog, stall limit 4.
// Four behavioural RAM banks with one-cycle read latency sit behind the bank port.
module tb_accel_mem_arbiter;
    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int NB  = 4;
    localparam int BAW = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       core_done = 1'b0;
    logic       done, busy, core_start, core_abort;
    logic [1:0] accel_state, accel_error;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    accel_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BANKS(NB)) mif ();

    accel_mem_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BANKS(NB),
        .TIMEOUT_CYCLES(16), .STALL_MAX(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .done(done), .busy(busy),
        .accel_state(accel_state), .accel_error(accel_error),
        .core_start(core_start), .core_abort(core_abort), .core_done(core_done),
        .mif(mif)
    );

    logic [DW-1:0] ram [NB][256];
    logic [DW-1:0] rdq [NB];

    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (mif.bank_en[b]) begin
                if (mif.bank_we[b]) begin
                    for (int k = 0; k < DW/8; k++) begin
                        if (mif.bank_be[b*(DW/8)+k])
                            ram[b][mif.bank_addr[b*BAW +: BAW]][k*8 +: 8] <= mif.bank_wdata[b*DW + k*8 +: 8];
                    end
                end else begin
                    rdq[b] <= ram[b][mif.bank_addr[b*BAW +: BAW]];
                end
            end
        end
    end

    assign mif.bank_rdata = {rdq[3], rdq[2], rdq[1], rdq[0]};

    task automatic test_reset();
        #12;
        n_chk++; if (accel_state !== 2'd0) $display("FAIL reset_state got %0d want 0", accel_state); else n_pass++;
        n_chk++; if (accel_error !== 2'b00) $display("FAIL reset_error got %b want 00", accel_error); else n_pass++;
        n_chk++;
        if ({done, busy, core_start, core_abort, mif.mem_rvalid, mif.core_rvalid} !== 6'b0)
            $display("FAIL reset_flags got %b want 000000",
                     {done, busy, core_start, core_abort, mif.mem_rvalid, mif.core_rvalid});
        else n_pass++;
        n_chk++;
        if ({mif.mem_rdata, mif.core_rdata} !== 64'h0)
            $display("FAIL reset_rdata got %h/%h want 0/0", mif.mem_rdata, mif.core_rdata);
        else n_pass++;
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        n_chk++; if (accel_state !== 2'd0) $display("FAIL post_reset_state got %0d want 0", accel_state); else n_pass++;
    endtask

    task automatic test_run_handshake();
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        n_chk++; if ({accel_state, core_start} !== 3'b011) $display("FAIL hs_entry got state=%0d cs=%b want 1/1", accel_state, core_start); else n_pass++;
        @(negedge clk);
        n_chk++; if ({busy, core_start} !== 2'b10) $display("FAIL hs_pulse got busy=%b cs=%b want 1/0", busy, core_start); else n_pass++;
        repeat (8) @(negedge clk);
        core_done = 1'b1;
        @(negedge clk) core_done = 1'b0;
        n_chk++; if ({accel_state, done} !== 3'b101) $display("FAIL hs_done got state=%0d done=%b want 2/1", accel_state, done); else n_pass++;
        start = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({accel_state, done, core_abort} !== 4'b0000)
            $display("FAIL hs_idle got state=%0d done=%b abort=%b want 0/0/0", accel_state, done, core_abort);
        else n_pass++;
    endtask

    task automatic test_interleave();
        logic [DW-1:0] exp;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            mif.mem_req = 1'b1; mif.mem_we = 1'b1; mif.mem_addr = AW'(i);
            mif.mem_be = 4'hF; mif.mem_wdata = 32'hA0 + DW'(i);
            #1;
            n_chk++; if (mif.mem_gnt !== 1'b1) $display("FAIL il_wr_gnt%0d got %b want 1", i, mif.mem_gnt); else n_pass++;
            if (i == 1 || i == 5) begin
                n_chk++;
                if ({mif.bank_en, mif.bank_addr[15:8]} !== {4'b0010, 8'(i / 4)})
                    $display("FAIL il_map%0d got en=%b a1=%0d want 0010/%0d", i, mif.bank_en, mif.bank_addr[15:8], i / 4);
                else n_pass++;
            end
            if (i == 6) begin
                n_chk++;
                if ({mif.bank_en, mif.bank_addr[23:16]} !== {4'b0100, 8'd1})
                    $display("FAIL il_map6 got en=%b a2=%0d want 0100/1", mif.bank_en, mif.bank_addr[23:16]);
                else n_pass++;
            end
        end
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                exp = 32'hA0 + DW'(i - 1);
                n_chk++;
                if ({mif.mem_rvalid, mif.mem_rdata} !== {1'b1, exp})
                    $display("FAIL il_rd%0d got v=%b d=%h want 1/%h", i - 1, mif.mem_rvalid, mif.mem_rdata, exp);
                else n_pass++;
            end
            if (i < 8) begin
                mif.mem_we = 1'b0; mif.mem_addr = AW'(i);
            end else begin
                mif.mem_req = 1'b0;
            end
        end
        @(negedge clk);
        n_chk++;
        if ({mif.mem_rvalid, mif.mem_rdata} !== {1'b0, 32'hA7})
            $display("FAIL il_hold got v=%b d=%h want 0/a7", mif.mem_rvalid, mif.mem_rdata);
        else n_pass++;
    endtask

    task automatic test_fairness();
        logic [1:0] exp;
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        mif.core_req = 1'b1; mif.core_we = 1'b0; mif.core_addr = 10'd0;
        mif.mem_req  = 1'b1; mif.mem_we  = 1'b0; mif.mem_addr  = 10'd4;
        for (int c = 0; c < 10; c++) begin
            #1;
            exp = (c % 5 == 4) ? 2'b10 : 2'b01;
            n_chk++;
            if ({mif.mem_gnt, mif.core_gnt} !== exp)
                $display("FAIL fair_c%0d got mem/core gnt=%b want %b", c, {mif.mem_gnt, mif.core_gnt}, exp);
            else n_pass++;
            if (c == 1) begin
                n_chk++;
                if ({mif.core_rvalid, mif.core_rdata} !== {1'b1, 32'hA0})
                    $display("FAIL fair_core_rd got v=%b d=%h want 1/a0", mif.core_rvalid, mif.core_rdata);
                else n_pass++;
            end
            if (c == 5) begin
                n_chk++;
                if ({mif.mem_rvalid, mif.mem_rdata, mif.core_rvalid} !== {1'b1, 32'hA4, 1'b0})
                    $display("FAIL fair_bus_rd got v=%b d=%h cv=%b want 1/a4/0", mif.mem_rvalid, mif.mem_rdata, mif.core_rvalid);
                else n_pass++;
            end
            @(negedge clk);
        end
        mif.core_req = 1'b0; mif.mem_req = 1'b0; core_done = 1'b1;
        @(negedge clk) core_done = 1'b0;
        n_chk++; if (accel_state !== 2'd2) $display("FAIL fair_done got state=%0d want 2", accel_state); else n_pass++;
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        @(negedge clk) start = 1'b1;
        repeat (16) @(negedge clk);
        n_chk++; if (accel_state !== 2'd1) $display("FAIL to_last_run got state=%0d want 1", accel_state); else n_pass++;
        @(negedge clk);
        n_chk++;
        if ({accel_state, accel_error, done} !== 5'b11_01_1)
            $display("FAIL to_error got state=%0d err=%b done=%b want 3/01/1", accel_state, accel_error, done);
        else n_pass++;
        start = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({accel_state, accel_error} !== 4'b00_01)
            $display("FAIL to_sticky got state=%0d err=%b want 0/01", accel_state, accel_error);
        else n_pass++;
        start = 1'b1;
        repeat (16) @(negedge clk);
        core_done = 1'b1;
        @(negedge clk) core_done = 1'b0;
        n_chk++;
        if ({accel_state, accel_error} !== 4'b10_00)
            $display("FAIL to_done_wins got state=%0d err=%b want 2/00", accel_state, accel_error);
        else n_pass++;
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_illegal_abort();
        @(negedge clk) mif.core_req = 1'b1; mif.core_addr = 10'd3;
        #1;
        n_chk++; if (mif.core_gnt !== 1'b0) $display("FAIL ill_gnt got %b want 0", mif.core_gnt); else n_pass++;
        @(negedge clk) mif.core_req = 1'b0;
        n_chk++; if (accel_error !== 2'b10) $display("FAIL ill_err got %b want 10", accel_error); else n_pass++;
        start = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({accel_state, accel_error} !== 4'b01_00)
            $display("FAIL ab_entry got state=%0d err=%b want 1/00", accel_state, accel_error);
        else n_pass++;
        repeat (2) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({accel_state, core_abort} !== 3'b001)
            $display("FAIL ab_pulse got state=%0d abort=%b want 0/1", accel_state, core_abort);
        else n_pass++;
        mif.core_req = 1'b1;
        @(negedge clk) mif.core_req = 1'b0;
        n_chk++;
        if ({core_abort, accel_error} !== 3'b0_10)
            $display("FAIL ab_after got abort=%b err=%b want 0/10", core_abort, accel_error);
        else n_pass++;
        start = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({accel_state, accel_error} !== 4'b01_00)
            $display("FAIL ab_restart got state=%0d err=%b want 1/00", accel_state, accel_error);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        mif.mem_req = 1'b1; mif.mem_we = 1'b0; mif.mem_addr = 10'd2;
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({accel_state, accel_error, done, busy, core_start, core_abort, mif.mem_rvalid} !== 9'b0)
            $display("FAIL rst_async got state=%0d err=%b d/b/cs/ca/rv=%b want all 0", accel_state, accel_error,
                     {done, busy, core_start, core_abort, mif.mem_rvalid});
        else n_pass++;
        start = 1'b0; mif.mem_req = 1'b0;
        @(posedge clk) #1;
        n_chk++; if (mif.bank_en !== 4'b0) $display("FAIL rst_bank_en got %b want 0000", mif.bank_en); else n_pass++;
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        mif.mem_req = 1'b0; mif.mem_addr = '0; mif.mem_we = 1'b0; mif.mem_be = '0; mif.mem_wdata = '0;
        mif.core_req = 1'b0; mif.core_addr = '0; mif.core_we = 1'b0; mif.core_be = 4'hF; mif.core_wdata = '0;
        test_reset();
        test_run_handshake();
        test_interleave();
        test_fairness();
        test_timeout();
        test_illegal_abort();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/accel_mem_arbiter.md
Name: accel_mem_arbiter

Overview:
- Next-generation memory front-end for template accelerators. Replaces the single-port, start-level mux with an N-bank, word-interleaved memory arbiter.
- Two masters share the banks: the peripheral bus and the accelerator core.
- Also owns the run-control FSM (start/done handshake, watchdog, abort) and sticky error flags.
- Sits between the APB/bus-side register/memory decoder and NUM_BANKS external single-port RAM banks.

Parameters:
- ADDR_WIDTH, 10, word address width seen by bus and core.
- DATA_WIDTH, 32, data width; multiple of 8.
- NUM_BANKS, 2, number of interleaved banks; power of two, 1..8.
- TIMEOUT_CYCLES, 4096, watchdog limit in RUN; 0 disables the watchdog.
- STALL_MAX, 4, consecutive bus stall cycles before bus gets forced priority.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- start  in  1  run request, level.
- done  out  1  run finished (DONE or ERROR state).
- busy  out  1  state == RUN.
- accel_state  out  2  IDLE=0, RUN=1, DONE=2, ERROR=3.
- accel_error  out  2  sticky; [0] timeout, [1] core access outside RUN.
- core_start  out  1  one-cycle pulse on entry to RUN.
- core_abort  out  1  one-cycle pulse when start drops while in RUN.
- core_done  in  1  core completion, sampled in RUN only.
- mem_req / core_req  in  1  access request (bus / core).
- mem_addr / core_addr  in  ADDR_WIDTH  word address.
- mem_we / core_we  in  1  write enable.
- mem_be / core_be  in  DATA_WIDTH/8  byte enables.
- mem_wdata / core_wdata  in  DATA_WIDTH  write data.
- mem_gnt / core_gnt  out  1  request accepted this cycle (combinational).
- mem_rvalid / core_rvalid  out  1  read data valid.
- mem_rdata / core_rdata  out  DATA_WIDTH  read data.
- bank_en  out  NUM_BANKS  per-bank enable.
- bank_we  out  NUM_BANKS  per-bank write enable.
- bank_addr  out  NUM_BANKS*BAW  packed bank addresses; BAW = ADDR_WIDTH - log2(NUM_BANKS).
- bank_be  out  NUM_BANKS*DATA_WIDTH/8  packed byte enables.
- bank_wdata  out  NUM_BANKS*DATA_WIDTH  packed write data.
- bank_rdata  in  NUM_BANKS*DATA_WIDTH  packed read data; valid 1 cycle after bank_en with bank_we=0.

Behaviour:
- Reset values: state=IDLE, done=0, busy=0, accel_error=0, core_start=0, core_abort=0, rvalids=0, rdata=0, watchdog=0, stall counter=0.
- Address mapping: bank = addr[log2(NUM_BANKS)-1:0]; bank address = addr[ADDR_WIDTH-1:log2(NUM_BANKS)]. When NUM_BANKS=1, bank=0 and bank address = addr.
- FSM, IDLE:
  - A rising edge of start (registered start_q=0, start=1) moves to RUN.
  - On entry to RUN: core_start=1 for one cycle, watchdog cleared, accel_error cleared.
- FSM, RUN:
  - core_done=1 -> DONE.
  - Otherwise watchdog == TIMEOUT_CYCLES-1 (with TIMEOUT_CYCLES != 0) -> ERROR and set accel_error[0].
  - Otherwise start=0 -> IDLE with core_abort=1 for one cycle.
  - Priority when several hold in the same cycle: core_done > timeout > abort.
- FSM, DONE and ERROR: done=1; stay until start=0, then go to IDLE.
- Arbitration outside RUN:
  - Bus is always granted: mem_gnt = mem_req.
  - core_gnt=0. A core_req here sets accel_error[1] (sticky until the next RUN entry).
- Arbitration in RUN, normal case:
  - core_gnt = core_req.
  - mem_gnt = mem_req when the target bank differs from the core's; 0 when both target the same bank (bus stalls).
- Arbitration in RUN, fairness:
  - The stall counter increments on each cycle with mem_req=1 and mem_gnt=0. It clears on any bus grant or when mem_req=0.
  - When the counter == STALL_MAX, a same-bank conflict grants the bus instead: mem_gnt=1, core_gnt=0. The counter then clears.
- Bank drive: the granted master drives bank_en/we/addr/be/wdata of its bank. At most two banks are active per cycle; unused banks have bank_en=0.
- Reads:
  - A granted read at cycle t gives rvalid=1 at t+1.
  - The bank index is registered at t; rdata at t+1 is muxed from that bank's bank_rdata.
  - Bus and core read paths are independent. rdata holds its last value when rvalid=0.
- Writes: take effect in the bank at the grant cycle; no rvalid.
- A state change to IDLE in the same cycle as an outstanding read does not suppress that read's rvalid.

Test Plan:
- Reset mid-RUN: assert rst_n=0 asynchronously -> all outputs at reset values immediately; bank_en=0 on the next edge.
- Run handshake: start 0->1 -> core_start pulse at the next edge; core_done after 10 cycles -> state DONE, done=1. Drop start -> IDLE, done=0.
- Interleave, NUM_BANKS=4: bus writes 0xA0+i to addresses 0..7 in IDLE, then reads them -> bank 1 bank_addr 0 and 1 hit for addresses 1 and 5; rdata correct with rvalid at +1 cycle.
- Conflict plus fairness, STALL_MAX=4: in RUN, core and bus both read bank 0 every cycle -> bus stalls 4 cycles, granted on the 5th with core_gnt=0; the pattern repeats.
- Timeout, TIMEOUT_CYCLES=16: start, never assert core_done -> ERROR after 16 RUN cycles, accel_error=2'b01, done=1. core_done and timeout in the same cycle -> DONE, error 0.
- Illegal core access plus abort: core_req in IDLE -> accel_error[1]=1, core_gnt=0. Start then drop start after 3 cycles -> core_abort pulse, IDLE. Next start clears accel_error.
